// File: rtl/fix_parser_pkg.sv
// Shared types and ASCII constants for the FIX field controller and its checksum helper.
package fix_parser_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TAG   = 3'd1,
        VALUE = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_TAG   = 2'b01,
        ERR_VALUE = 2'b10,
        ERR_MSG   = 2'b11
    } err_code_e;

    localparam logic [7:0] SOH      = 8'h01;
    localparam logic [7:0] EQ       = 8'h3D;
    localparam logic [7:0] DIGIT_LO = 8'h30;
    localparam logic [7:0] DIGIT_HI = 8'h39;

    // Tag constants are in string-literal order ("10" == 16'h3130); tag_o keeps the first char low.
    localparam logic [15:0] TAG_BEGIN = 16'h0038;
    localparam logic [15:0] TAG_CKSUM = 16'h3130;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= DIGIT_LO) && (b <= DIGIT_HI);
    endfunction

    function automatic logic tag_match(input logic [15:0] tag, input int len, input logic [15:0] str);
        if (str[15:8] == 8'h00)
            return (len == 1) && (tag[7:0] == str[7:0]);
        return (len == 2) && (tag[7:0] == str[15:8]) && (tag[15:8] == str[7:0]);
    endfunction

endpackage

// File: rtl/fix_parser_field_ctrl_if.sv
// Byte-ingress and field-egress bundle of the FIX field controller.
interface fix_parser_field_ctrl_if #(
    parameter int MAX_TAG_BYTES   = 4,
    parameter int MAX_VALUE_BYTES = 32
);
    localparam int TAG_W  = 8 * MAX_TAG_BYTES;
    localparam int VAL_W  = 8 * MAX_VALUE_BYTES;
    localparam int TLEN_W = $clog2(MAX_TAG_BYTES + 1);
    localparam int VLEN_W = $clog2(MAX_VALUE_BYTES + 1);

    logic [7:0]        data_i;
    logic              valid_i;
    logic              ready_o;
    logic [TAG_W-1:0]  tag_o;
    logic [TLEN_W-1:0] tag_len_o;
    logic [VAL_W-1:0]  value_o;
    logic [VLEN_W-1:0] value_len_o;
    logic              field_valid_o;
    logic              field_ready_i;
    logic              start_of_header_o;
    logic              end_of_body_o;
    logic              err_o;
    logic [1:0]        err_code_o;
    logic              cksum_err_o;

    modport slave (
        input  data_i, valid_i, field_ready_i,
        output ready_o, tag_o, tag_len_o, value_o, value_len_o, field_valid_o,
               start_of_header_o, end_of_body_o, err_o, err_code_o, cksum_err_o
    );

    modport master (
        output data_i, valid_i, field_ready_i,
        input  ready_o, tag_o, tag_len_o, value_o, value_len_o, field_valid_o,
               start_of_header_o, end_of_body_o, err_o, err_code_o, cksum_err_o
    );

endinterface

// File: rtl/fix_checksum_calc.sv
// Modulo-256 FIX checksum: per-field partial sum, message snapshot at each SOH, ASCII-decimal compare.
module fix_checksum_calc
    import fix_parser_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        accept,
    input  logic [7:0]  din,
    input  logic        restart,
    input  logic [23:0] digits,
    input  logic        len_is_3,
    output logic        bad
);
    logic [7:0] field_sum, msg_sum, field_tot;
    logic [3:0] d0, d1, d2;
    logic [9:0] val;
    logic       all_digits;

    assign field_tot = field_sum + din;

    // A tag-8 field restarts the message sum from its own first byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            field_sum <= 8'd0;
            msg_sum   <= 8'd0;
        end else if (accept) begin
            if (din == SOH) begin
                field_sum <= 8'd0;
                msg_sum   <= (restart ? 8'd0 : msg_sum) + field_tot;
            end else begin
                field_sum <= field_tot;
            end
        end
    end

    always_comb begin
        d0         = 4'(digits[7:0]   - DIGIT_LO);
        d1         = 4'(digits[15:8]  - DIGIT_LO);
        d2         = 4'(digits[23:16] - DIGIT_LO);
        all_digits = is_digit(digits[7:0]) && is_digit(digits[15:8]) && is_digit(digits[23:16]);
        val        = 10'(d0) * 10'd100 + 10'(d1) * 10'd10 + 10'(d2);
        bad        = !(len_is_3 && all_digits) || (val != {2'b00, msg_sum});
    end

endmodule

// File: rtl/fix_parser_field_ctrl.sv
// Framing controller for a FIX byte stream: splits tag=value<SOH> fields and tracks message bounds.
// Checksum verification of tag 10 is built only when FIX_CHECKSUM_EN is defined.
module fix_parser_field_ctrl
    import fix_parser_pkg::*;
#(
    parameter int MAX_TAG_BYTES   = 4,
    parameter int MAX_VALUE_BYTES = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    fix_parser_field_ctrl_if.slave bus
);
    localparam int TAG_W  = 8 * MAX_TAG_BYTES;
    localparam int VAL_W  = 8 * MAX_VALUE_BYTES;
    localparam int TLEN_W = $clog2(MAX_TAG_BYTES + 1);
    localparam int VLEN_W = $clog2(MAX_VALUE_BYTES + 1);
    localparam logic [TLEN_W-1:0] TAG_FULL = TLEN_W'(MAX_TAG_BYTES);
    localparam logic [VLEN_W-1:0] VAL_FULL = VLEN_W'(MAX_VALUE_BYTES);

    state_e            state, state_nxt;
    logic [TAG_W-1:0]  tag_buf;
    logic [TLEN_W-1:0] tag_cnt;
    logic [VAL_W-1:0]  val_buf;
    logic [VLEN_W-1:0] val_cnt;
    logic [7:0]        din;
    logic              ready, field_valid, accept, take;
    logic              is_begin, is_cksum, in_msg, emit, cksum_bad;
    logic              err_fire;
    err_code_e         err_nxt;

    logic [TAG_W-1:0]  tag_p1;
    logic [TLEN_W-1:0] tag_len_p1;
    logic [VAL_W-1:0]  value_p1;
    logic [VLEN_W-1:0] value_len_p1;
    logic              soh_p1, eob_p1, cksum_err_p1, err_p1;
    err_code_e         err_code_p1;

    assign din      = bus.data_i;
    assign accept   = bus.valid_i && ready;
    assign take     = field_valid && bus.field_ready_i;
    assign is_begin = tag_match(tag_buf[15:0], int'(tag_cnt), TAG_BEGIN);
    assign is_cksum = tag_match(tag_buf[15:0], int'(tag_cnt), TAG_CKSUM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_fire  = 1'b0;
        err_nxt   = ERR_NONE;
        emit      = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (is_digit(din)) begin
                    state_nxt = TAG;
                end else begin
                    state_nxt = DRAIN;
                    err_fire  = 1'b1;
                    err_nxt   = ERR_TAG;
                end
            end
            TAG: if (accept) begin
                if (din == EQ) begin
                    state_nxt = VALUE;
                end else if (din == SOH) begin
                    state_nxt = IDLE;
                    err_fire  = 1'b1;
                    err_nxt   = ERR_TAG;
                end else if (!is_digit(din) || tag_cnt == TAG_FULL) begin
                    state_nxt = DRAIN;
                    err_fire  = 1'b1;
                    err_nxt   = ERR_TAG;
                end
            end
            VALUE: if (accept) begin
                if (din == SOH) begin
                    if (val_cnt == '0) begin
                        state_nxt = IDLE;
                        err_fire  = 1'b1;
                        err_nxt   = ERR_VALUE;
                    end else if (!in_msg && !is_begin) begin
                        state_nxt = IDLE;
                        err_fire  = 1'b1;
                        err_nxt   = ERR_MSG;
                    end else begin
                        state_nxt = HOLD;
                        emit      = 1'b1;
                    end
                end else if (val_cnt == VAL_FULL) begin
                    state_nxt = DRAIN;
                    err_fire  = 1'b1;
                    err_nxt   = ERR_VALUE;
                end
            end
            HOLD:    if (bus.field_ready_i) state_nxt = IDLE;
            DRAIN:   if (accept && din == SOH) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready       = 1'b1;
        field_valid = 1'b0;
        if (state == HOLD) begin
            ready       = 1'b0;
            field_valid = 1'b1;
        end
    end

    // Assembly buffers are re-initialised by the first byte of every field, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            case (state)
                IDLE: begin
                    tag_buf <= TAG_W'(din);
                    tag_cnt <= TLEN_W'(1);
                    val_buf <= '0;
                    val_cnt <= '0;
                end
                TAG: if (is_digit(din) && tag_cnt != TAG_FULL) begin
                    tag_buf[8*tag_cnt +: 8] <= din;
                    tag_cnt                 <= tag_cnt + TLEN_W'(1);
                end
                VALUE: if (din != SOH && val_cnt != VAL_FULL) begin
                    val_buf[8*val_cnt +: 8] <= din;
                    val_cnt                 <= val_cnt + VLEN_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef FIX_CHECKSUM_EN
    fix_checksum_calc u_cksum (
        .clk      (clk),
        .rst      (rst),
        .accept   (accept),
        .din      (din),
        .restart  (emit && is_begin),
        .digits   (val_buf[23:0]),
        .len_is_3 (val_cnt == VLEN_W'(3)),
        .bad      (cksum_bad)
    );
`else
    assign cksum_bad = 1'b0;
`endif

    // Presentation stage: loaded at the field's SOH, cleared when the consumer takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_p1       <= '0;
            tag_len_p1   <= '0;
            value_p1     <= '0;
            value_len_p1 <= '0;
            soh_p1       <= 1'b0;
            eob_p1       <= 1'b0;
            cksum_err_p1 <= 1'b0;
            err_p1       <= 1'b0;
            err_code_p1  <= ERR_NONE;
            in_msg       <= 1'b0;
        end else begin
            err_p1 <= err_fire;
            if (err_fire) err_code_p1 <= err_nxt;
            if (emit) begin
                tag_p1       <= tag_buf;
                tag_len_p1   <= tag_cnt;
                value_p1     <= val_buf;
                value_len_p1 <= val_cnt;
                soh_p1       <= is_begin;
                eob_p1       <= is_cksum;
                cksum_err_p1 <= is_cksum && cksum_bad;
                if (is_begin) in_msg <= 1'b1;
            end else if (take) begin
                tag_p1       <= '0;
                tag_len_p1   <= '0;
                value_p1     <= '0;
                value_len_p1 <= '0;
                soh_p1       <= 1'b0;
                eob_p1       <= 1'b0;
                cksum_err_p1 <= 1'b0;
                if (eob_p1) in_msg <= 1'b0;
            end
        end
    end

    assign bus.ready_o           = ready;
    assign bus.field_valid_o     = field_valid;
    assign bus.tag_o             = tag_p1;
    assign bus.tag_len_o         = tag_len_p1;
    assign bus.value_o           = value_p1;
    assign bus.value_len_o       = value_len_p1;
    assign bus.start_of_header_o = soh_p1;
    assign bus.end_of_body_o     = eob_p1;
    assign bus.cksum_err_o       = cksum_err_p1;
    assign bus.err_o             = err_p1;
    assign bus.err_code_o        = err_code_p1;

endmodule

// File: tb/tb_fix_parser_field_ctrl.sv
// Directed FIX byte strings; expected fields and error codes are queued and popped by a monitor.
module tb_fix_parser_field_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fix_parser_field_ctrl_if #(.MAX_TAG_BYTES(4), .MAX_VALUE_BYTES(32)) bus ();

    fix_parser_field_ctrl #(.MAX_TAG_BYTES(4), .MAX_VALUE_BYTES(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0]  tag;
        logic [2:0]   tlen;
        logic [255:0] val;
        logic [5:0]   vlen;
        logic [2:0]   flags;
    } fld_t;

    fld_t       exp_q[$];
    logic [1:0] err_q[$];
    fld_t       mon_e;
    logic [1:0] mon_code;
    int         checks = 0;
    int         errors = 0;
    string      s32;

`ifdef FIX_CHECKSUM_EN
    localparam logic CK_ON = 1'b1;
`else
    localparam logic CK_ON = 1'b0;
`endif

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] pack(input string s);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[i];
        return r;
    endfunction

    task automatic push_field(input string t, input string v, input logic sh, input logic eb, input logic ck);
        fld_t f;
        logic [255:0] tp;
        tp      = pack(t);
        f.tag   = tp[31:0];
        f.tlen  = 3'(t.len());
        f.val   = pack(v);
        f.vlen  = 6'(v.len());
        f.flags = {sh, eb, ck};
        exp_q.push_back(f);
    endtask

    task automatic send_byte(input logic [7:0] v);
        int guard;
        guard       = 0;
        bus.data_i  = v;
        bus.valid_i = 1'b1;
        while (!bus.ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready_o=%0b expected 1 within 100 cycles", bus.ready_o);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            send_byte((c == 8'h7C) ? 8'h01 : c);
        end
        bus.valid_i = 1'b0;
    endtask

    // Monitor: a field is consumed where valid && ready; every err_o pulse consumes one expected code.
    always begin
        @(negedge clk);
        #1;
        if (rst && bus.field_valid_o && bus.field_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_field: got tag %0h expected no field", bus.tag_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("field_tag",   256'(bus.tag_o),       256'(mon_e.tag));
                chk("field_tlen",  256'(bus.tag_len_o),   256'(mon_e.tlen));
                chk("field_value", bus.value_o,           mon_e.val);
                chk("field_vlen",  256'(bus.value_len_o), 256'(mon_e.vlen));
                chk("field_flags", 256'({bus.start_of_header_o, bus.end_of_body_o, bus.cksum_err_o}),
                    256'(mon_e.flags));
            end
        end
        if (rst && bus.err_o) begin
            if (err_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_err: got code %0h expected no error", bus.err_code_o);
            end else begin
                mon_code = err_q.pop_front();
                chk("err_code", 256'(bus.err_code_o), 256'(mon_code));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.data_i        = 8'h00;
        bus.valid_i       = 1'b0;
        bus.field_ready_i = 1'b0;
        s32 = "";
        for (int i = 0; i < 32; i++) s32 = {s32, "Z"};

        repeat (3) @(negedge clk);
        chk("rst_ready",    256'(bus.ready_o),       256'(1));
        chk("rst_valid",    256'(bus.field_valid_o), 256'(0));
        chk("rst_err",      256'(bus.err_o),         256'(0));
        chk("rst_err_code", 256'(bus.err_code_o),    256'(0));
        chk("rst_tag",      256'(bus.tag_o),         256'(0));
        chk("rst_value",    bus.value_o,             256'(0));
        chk("rst_flags",    256'({bus.start_of_header_o, bus.end_of_body_o, bus.cksum_err_o}), 256'(0));
        rst = 1'b1;
        @(negedge clk);

        bus.field_ready_i = 1'b1;
        push_field("8", "FIX.4.2", 1'b1, 1'b0, 1'b0);
        send_str("8=FIX.4.2|");
        chk("latency_valid", 256'(bus.field_valid_o), 256'(1));
        chk("latency_tag",   256'(bus.tag_o),         256'(32'h38));
        chk("latency_vlen",  256'(bus.value_len_o),   256'(7));
        @(negedge clk);

        bus.field_ready_i = 1'b0;
        push_field("35", "D", 1'b0, 1'b0, 1'b0);
        send_str("35=D|");
        for (int i = 0; i < 5; i++) begin
            chk("hold_ready", 256'(bus.ready_o),       256'(0));
            chk("hold_valid", 256'(bus.field_valid_o), 256'(1));
            chk("hold_tag",   256'(bus.tag_o),         256'(32'h3533));
            chk("hold_value", bus.value_o,             256'(8'h44));
            @(negedge clk);
        end
        bus.field_ready_i = 1'b1;
        @(negedge clk);
        chk("release_ready", 256'(bus.ready_o),       256'(1));
        chk("release_valid", 256'(bus.field_valid_o), 256'(0));

        err_q.push_back(2'b01);
        send_str("12345=X|");
        push_field("49", "A", 1'b0, 1'b0, 1'b0);
        send_str("49=A|");

        push_field("1234", "Q", 1'b0, 1'b0, 1'b0);
        send_str("1234=Q|");
        push_field("58", s32, 1'b0, 1'b0, 1'b0);
        send_str({"58=", s32, "|"});

        err_q.push_back(2'b10);
        send_str("7=|");

        push_field("8",  "A",   1'b1, 1'b0, 1'b0);
        push_field("9",  "1",   1'b0, 1'b0, 1'b0);
        push_field("10", "095", 1'b0, 1'b1, 1'b0);
        send_str("8=A|9=1|10=095|");
        push_field("8",  "A",   1'b1, 1'b0, 1'b0);
        push_field("9",  "1",   1'b0, 1'b0, 1'b0);
        push_field("10", "096", 1'b0, 1'b1, CK_ON);
        send_str("8=A|9=1|10=096|");

        err_q.push_back(2'b11);
        send_str("55=Y|");
        err_q.push_back(2'b10);
        send_str({"7=", s32, "Z|"});
        repeat (3) @(negedge clk);
        chk("err_code_held", 256'(bus.err_code_o), 256'(2'b10));

        err_q.push_back(2'b01);
        send_str("A=1|");
        err_q.push_back(2'b11);
        send_str("10=000|");

        send_str("8=BC");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_ready",    256'(bus.ready_o),    256'(1));
        chk("midrst_err_code", 256'(bus.err_code_o), 256'(0));
        rst = 1'b1;
        @(negedge clk);
        push_field("8", "B", 1'b1, 1'b0, 1'b0);
        send_str("8=B|");

        repeat (5) @(negedge clk);
        chk("fields_pending", 256'(exp_q.size()), 256'(0));
        chk("errors_pending", 256'(err_q.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
